// File: rtl/global_mem_bank_arbiter.sv
// global_mem_bank_arbiter: round-robin arbiter sharing one global memory bank port, with read return routing and activity counters
module global_mem_bank_arbiter #(
  parameter int N_REQ       = 64,
  parameter int DATA_L      = 32,
  parameter int BANK_ADDR_L = 16,
  parameter int RD_LATENCY  = 1,
  parameter int CNT_L       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ-1:0]         req_wr_en,
  input  logic [N_REQ*BANK_ADDR_L-1:0] req_addr,
  input  logic [N_REQ*DATA_L-1:0]  req_wr_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     mem_ch_en,
  output logic                     mem_wr_en,
  output logic [BANK_ADDR_L-1:0]   mem_addr,
  output logic [DATA_L-1:0]        mem_wr_data,
  input  logic [DATA_L-1:0]        mem_rd_data,
  output logic [N_REQ-1:0]         rd_data_vld,
  output logic [DATA_L-1:0]        rd_data,
  input  logic                     cnt_clear,
  output logic [CNT_L-1:0]         rd_gnt_cnt,
  output logic [CNT_L-1:0]         wr_gnt_cnt,
  output logic [CNT_L-1:0]         conflict_cnt
);
  localparam int PTR_L = $clog2(N_REQ);
  logic [PTR_L-1:0] rr_q, rr_d, winner, idx;
  logic             any, wr_sel, rd_ev, wr_ev, conflict;
  logic             vld_q [RD_LATENCY];
  logic [PTR_L-1:0] id_q  [RD_LATENCY];
  logic [CNT_L-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, cf_cnt_q, cf_cnt_d;
  // Scan downwards so the closest requester after rr_q is the last one written.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k >= N_REQ) ? PTR_L'(int'(rr_q) + k - N_REQ) : PTR_L'(int'(rr_q) + k);
      if (req_vld[idx]) winner = idx;
    end
  end
  assign any         = |req_vld;
  assign wr_sel      = req_wr_en[winner];
  assign rd_ev       = any & ~wr_sel;
  assign wr_ev       = any & wr_sel;
  assign conflict    = $countones(req_vld) > 1;
  assign rr_d        = (winner == PTR_L'(N_REQ - 1)) ? '0 : winner + PTR_L'(1);
  assign gnt         = any ? N_REQ'(1) << winner : '0;
  assign mem_ch_en   = any;
  assign mem_wr_en   = wr_ev;
  assign mem_addr    = any ? req_addr[int'(winner)*BANK_ADDR_L +: BANK_ADDR_L] : '0;
  assign mem_wr_data = any ? req_wr_data[int'(winner)*DATA_L +: DATA_L] : '0;
  assign rd_data_vld = vld_q[RD_LATENCY-1] ? N_REQ'(1) << id_q[RD_LATENCY-1] : '0;
  assign rd_data     = mem_rd_data;
  assign rd_cnt_d    = cnt_clear ? '0 : (rd_ev && !(&rd_cnt_q)) ? rd_cnt_q + CNT_L'(1) : rd_cnt_q;
  assign wr_cnt_d    = cnt_clear ? '0 : (wr_ev && !(&wr_cnt_q)) ? wr_cnt_q + CNT_L'(1) : wr_cnt_q;
  assign cf_cnt_d    = cnt_clear ? '0 : (conflict && !(&cf_cnt_q)) ? cf_cnt_q + CNT_L'(1) : cf_cnt_q;
  assign rd_gnt_cnt   = rd_cnt_q;
  assign wr_gnt_cnt   = wr_cnt_q;
  assign conflict_cnt = cf_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      cf_cnt_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        vld_q[s] <= 1'b0;
        id_q[s]  <= '0;
      end
    end else begin
      if (any) rr_q <= rr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      cf_cnt_q <= cf_cnt_d;
      vld_q[0] <= rd_ev;
      id_q[0]  <= winner;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end
endmodule

// File: tb/tb_global_mem_bank_arbiter.sv
// tb_global_mem_bank_arbiter: directed and random stimulus against a queue-based reference model of the arbiter
module tb_global_mem_bank_arbiter;
  localparam int N = 64, DL = 32, AL = 16;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]    req_vld = '0, req_wr_en = '0;
  logic [N*AL-1:0] req_addr = '0;
  logic [N*DL-1:0] req_wr_data = '0;
  logic            cnt_clear = 1'b0;
  logic [N-1:0]    gnt, rd_data_vld, s_gnt, s_rd_data_vld;
  logic            mem_ch_en, mem_wr_en, s_ch, s_we;
  logic [AL-1:0]   mem_addr, s_addr;
  logic [DL-1:0]   mem_wr_data, mem_rd_data = '0, rd_data, s_wd, s_rdata;
  logic [31:0]     rd_gnt_cnt, wr_gnt_cnt, conflict_cnt;
  logic [3:0]      s_rd, s_wr, s_cf;
  global_mem_bank_arbiter dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr_en(req_wr_en), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .gnt(gnt), .mem_ch_en(mem_ch_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .cnt_clear(cnt_clear),
    .rd_gnt_cnt(rd_gnt_cnt), .wr_gnt_cnt(wr_gnt_cnt), .conflict_cnt(conflict_cnt));
  global_mem_bank_arbiter #(.CNT_L(4)) dut_sat (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr_en(req_wr_en), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .gnt(s_gnt), .mem_ch_en(s_ch), .mem_wr_en(s_we),
    .mem_addr(s_addr), .mem_wr_data(s_wd), .mem_rd_data(mem_rd_data),
    .rd_data_vld(s_rd_data_vld), .rd_data(s_rdata), .cnt_clear(cnt_clear),
    .rd_gnt_cnt(s_rd), .wr_gnt_cnt(s_wr), .conflict_cnt(s_cf));
  // Bank SRAM with one-cycle read latency, driven by the main instance.
  logic [DL-1:0] sram [int];
  always @(posedge clk)
    if (mem_ch_en) begin
      if (mem_wr_en) sram[int'(mem_addr)] = mem_wr_data;
      else mem_rd_data <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : '0;
    end
  typedef struct {int due; int id; logic [DL-1:0] data;} ret_t;
  ret_t q[$];
  logic [DL-1:0] m_mem [int];
  int m_ptr = 0, cyc = 0, errors = 0, checks = 0;
  longint m_rd = 0, m_wr = 0, m_cf = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] sat(longint v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction
  function automatic logic [DL-1:0] mread(int a);
    return m_mem.exists(a) ? m_mem[a] : '0;
  endfunction
  task automatic set_req(int i, bit wr, int a, logic [DL-1:0] d);
    req_vld[i] = 1'b1;
    req_wr_en[i] = wr;
    req_addr[i*AL +: AL] = AL'(a);
    req_wr_data[i*DL +: DL] = d;
  endtask
  task automatic clr_req();
    req_vld = '0;
    req_wr_en = '0;
  endtask
  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    int w, bestd, a;
    bit any, wr;
    logic [63:0] eg, ev;
    logic [DL-1:0] ed;
    @(negedge clk);
    if (rst) begin
      m_ptr = 0; m_rd = 0; m_wr = 0; m_cf = 0;
      q.delete();
    end
    any = |req_vld;
    w = 0;
    bestd = N;
    for (int i = 0; i < N; i++)
      if (req_vld[i] && ((i - m_ptr + N) % N) < bestd) begin
        bestd = (i - m_ptr + N) % N;
        w = i;
      end
    eg = any ? 64'd1 << w : 64'd0;
    wr = any && req_wr_en[w];
    a  = any ? int'(req_addr[w*AL +: AL]) : 0;
    ed = any ? req_wr_data[w*DL +: DL] : '0;
    chk("gnt", gnt, eg);
    chk("sat_gnt", s_gnt, eg);
    chk("mem_ch_en", mem_ch_en, any);
    chk("mem_wr_en", mem_wr_en, wr);
    chk("mem_addr", mem_addr, a);
    chk("mem_wr_data", mem_wr_data, ed);
    ev = 64'd0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 64'd1 << q[0].id;
      chk("rd_data", rd_data, q[0].data);
      void'(q.pop_front());
    end
    chk("rd_data_vld", rd_data_vld, ev);
    chk("rd_gnt_cnt", rd_gnt_cnt, m_rd);
    chk("wr_gnt_cnt", wr_gnt_cnt, m_wr);
    chk("conflict_cnt", conflict_cnt, m_cf);
    chk("sat_rd_cnt", s_rd, sat(m_rd));
    chk("sat_wr_cnt", s_wr, sat(m_wr));
    chk("sat_cf_cnt", s_cf, sat(m_cf));
    if (!rst) begin
      if (cnt_clear) begin
        m_rd = 0; m_wr = 0; m_cf = 0;
      end else begin
        if (any && wr) m_wr++;
        if (any && !wr) m_rd++;
        if ($countones(req_vld) >= 2) m_cf++;
      end
      if (any) begin
        if (wr) m_mem[a] = ed;
        else q.push_back('{due: cyc + 1, id: w, data: mread(a)});
        m_ptr = (w + 1) % N;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(5, 1'b1, 'h10, 32'hDEADBEEF);
    tick();
    set_req(5, 1'b0, 'h10, 32'h0);
    tick();
    clr_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_vld = '1;
    req_wr_en = '1;
    for (int i = 0; i < N; i++) req_addr[i*AL +: AL] = AL'(32 + i);
    for (int c = 0; c < 128; c++) tick();
    clr_req();
    tick();
    set_req(9, 1'b0, 1, 0);
    tick();
    clr_req();
    set_req(3, 1'b0, 2, 0);
    set_req(12, 1'b0, 3, 0);
    tick();
    req_vld[12] = 1'b0;
    tick();
    clr_req();
    set_req(2, 1'b0, 4, 0);
    set_req(4, 1'b0, 5, 0);
    tick();
    clr_req();
    foreach (req_vld[i]) if (i == 1 || i == 2 || i == 7) begin
      clr_req();
      set_req(i, 1'b1, 100 + i, $urandom);
      tick();
    end
    foreach (req_vld[i]) if (i == 1 || i == 2 || i == 7) begin
      clr_req();
      set_req(i, 1'b0, 100 + i, 0);
      tick();
    end
    clr_req();
    tick();
    set_req(4, 1'b0, 101, 0);
    tick();
    clr_req();
    chk("ret_before_rst", rd_data_vld, 64'd1 << 4);
    rst = 1'b1;
    #1;
    chk("rd_vld_in_rst", rd_data_vld, 64'd0);
    chk("rd_cnt_in_rst", rd_gnt_cnt, 64'd0);
    set_req(4, 1'b0, 102, 0);
    set_req(0, 1'b0, 103, 0);
    tick();
    rst = 1'b0;
    tick();
    req_vld[0] = 1'b0;
    tick();
    clr_req();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_req(6, 1'b0, c % 16, 0);
      tick();
    end
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    tick();
    clr_req();
    tick();
    for (int c = 0; c < 400; c++) begin
      cnt_clear = ($urandom_range(0, 60) == 0);
      req_vld = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) req_vld = '0;
      req_wr_en = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        req_addr[i*AL +: AL] = AL'($urandom_range(0, 15));
        req_wr_data[i*DL +: DL] = $urandom;
      end
      tick();
    end
    clr_req();
    cnt_clear = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
